// File: rtl/volume_level_ctrl.sv
`timescale 1ns/1ps
// Windowed-peak mic level meter: quantises each window's peak to 0..15 and steps the
// displayed level through attack/hold/decay, updating only on OLED frame boundaries.
module volume_level_ctrl #(
   parameter int SAMPLE_WIN   = 4000,
   parameter int HOLD_FRAMES  = 30,
   parameter int DECAY_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [11:0] mic_in,
   input  logic        frame_begin,
   input  logic        freeze,
   output logic [3:0]  level,
   output logic [3:0]  target,
   output logic        level_strobe,
   output logic [1:0]  state_dbg
);

   // Handshake: sample_valid and frame_begin are single-cycle strobes with no back-pressure;
   // every strobe is consumed on the edge that samples it.

   localparam int WW = (SAMPLE_WIN > 1)   ? $clog2(SAMPLE_WIN)       : 1;
   localparam int HW = (HOLD_FRAMES > 0)  ? $clog2(HOLD_FRAMES + 1)  : 1;
   localparam int DW = (DECAY_FRAMES > 0) ? $clog2(DECAY_FRAMES + 1) : 1;

   typedef enum logic [1:0] {
      ST_ATTACK = 2'd0,
      ST_HOLD   = 2'd1,
      ST_DECAY  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [11:0]     run_max_q, run_max_d;
   logic [WW-1:0]   win_cnt_q, win_cnt_d;
   logic [3:0]      target_q, target_d;
   logic [3:0]      level_q, level_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DW-1:0]   dec_cnt_q, dec_cnt_d;
   logic            strobe_q, strobe_d;
   logic [11:0]     peak;
   logic            frame_go;

   assign peak     = (mic_in > run_max_q) ? mic_in : run_max_q;
   assign frame_go = frame_begin & ~freeze;

   // Window unit runs regardless of freeze; bit 11 set means at or above the midpoint.
   always_comb begin
      run_max_d = run_max_q;
      win_cnt_d = win_cnt_q;
      target_d  = target_q;
      if (sample_valid) begin
         if (win_cnt_q == WW'(SAMPLE_WIN - 1)) begin
            target_d  = peak[11] ? peak[10:7] : 4'd0;
            run_max_d = '0;
            win_cnt_d = '0;
         end else begin
            run_max_d = peak;
            win_cnt_d = win_cnt_q + WW'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      hold_cnt_d = hold_cnt_q;
      dec_cnt_d  = dec_cnt_q;
      strobe_d   = frame_go;
      if (state_q == ST_ATTACK) state_d = ST_HOLD;
      if (frame_go) begin
         if (target_q > level_q) begin
            level_d    = target_q;
            hold_cnt_d = HW'(HOLD_FRAMES);
            state_d    = ST_ATTACK;
         end else begin
            case (state_q)
               ST_ATTACK, ST_HOLD: begin
                  if (hold_cnt_q > HW'(1)) begin
                     hold_cnt_d = hold_cnt_q - HW'(1);
                     state_d    = ST_HOLD;
                  end else begin
                     state_d   = ST_DECAY;
                     dec_cnt_d = DW'(DECAY_FRAMES);
                  end
               end
               ST_DECAY: begin
                  // target < level guarantees level >= 1, so the step cannot wrap.
                  if (target_q < level_q) begin
                     if (dec_cnt_q <= DW'(1)) begin
                        level_d   = level_q - 4'd1;
                        dec_cnt_d = DW'(DECAY_FRAMES);
                     end else begin
                        dec_cnt_d = dec_cnt_q - DW'(1);
                     end
                  end
               end
               default: state_d = ST_DECAY;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_DECAY;
         run_max_q  <= '0;
         win_cnt_q  <= '0;
         target_q   <= '0;
         level_q    <= '0;
         hold_cnt_q <= '0;
         dec_cnt_q  <= '0;
         strobe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_max_q  <= run_max_d;
         win_cnt_q  <= win_cnt_d;
         target_q   <= target_d;
         level_q    <= level_d;
         hold_cnt_q <= hold_cnt_d;
         dec_cnt_q  <= dec_cnt_d;
         strobe_q   <= strobe_d;
      end
   end

   assign level        = level_q;
   assign target       = target_q;
   assign level_strobe = strobe_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_volume_level_ctrl.sv
`timescale 1ns/1ps
// Bench for volume_level_ctrl: table-driven quantisation vectors, hand-written
// attack/hold/decay, freeze and collision sequences, and random traffic against a model.
module tb_volume_level_ctrl;

   localparam int SW = 4;
   localparam int HF = 2;
   localparam int DF = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] mic_in = '0;
   logic        frame_begin = 1'b0;
   logic        freeze = 1'b0;
   logic [3:0]  level;
   logic [3:0]  target;
   logic        level_strobe;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   volume_level_ctrl #(
      .SAMPLE_WIN  (SW),
      .HOLD_FRAMES (HF),
      .DECAY_FRAMES(DF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_valid(sample_valid),
      .mic_in      (mic_in),
      .frame_begin (frame_begin),
      .freeze      (freeze),
      .level       (level),
      .target      (target),
      .level_strobe(level_strobe),
      .state_dbg   (state_dbg)
   );

   // Reference model: window kept as a list of samples, level as plain integers.
   int          win_q[$];
   logic [3:0]  exp_q[$];
   int          m_target, m_level, m_hold_left, m_dec_left;
   bit          m_decaying, m_strobe;

   typedef struct {
      int s0, s1, s2, s3;
      int exp_target;
   } vec_t;
   vec_t vecs[6];

   function automatic int quant(int p);
      return (p < 2048) ? 0 : (p - 2048) / 128;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      win_q.delete();
      m_target = 0; m_level = 0; m_hold_left = 0; m_dec_left = 0;
      m_decaying = 1'b1; m_strobe = 1'b0;
   endtask

   task automatic step(input bit sv, input int mic, input bit fb, input bit frz);
      int old_t;
      int peak;
      @(negedge clk);
      sample_valid = sv; mic_in = 12'(mic); frame_begin = fb; freeze = frz;
      @(posedge clk);
      #1;
      old_t = m_target;
      if (sv) begin
         win_q.push_back(mic);
         if (win_q.size() == SW) begin
            peak = 0;
            foreach (win_q[i]) if (win_q[i] > peak) peak = win_q[i];
            m_target = quant(peak);
            win_q.delete();
         end
      end
      m_strobe = fb && !frz;
      if (m_strobe) begin
         if (old_t > m_level) begin
            m_level = old_t; m_hold_left = HF; m_decaying = 1'b0;
         end else if (!m_decaying) begin
            if (m_hold_left > 1) m_hold_left--;
            else begin m_decaying = 1'b1; m_dec_left = DF; end
         end else if (old_t < m_level) begin
            if (m_dec_left <= 1) begin m_level--; m_dec_left = DF; end
            else m_dec_left--;
         end
      end
      check("model_target", target, m_target);
      check("model_level", level, m_level);
      check("model_strobe", level_strobe, m_strobe);
      sample_valid = 1'b0; frame_begin = 1'b0;
   endtask

   task automatic send_window(input int a, input int b, input int c, input int d, input bit frz);
      step(1'b1, a, 1'b0, frz);
      step(1'b1, b, 1'b0, frz);
      step(1'b1, c, 1'b0, frz);
      step(1'b1, d, 1'b0, frz);
   endtask

   task automatic frame(input bit frz);
      step(1'b0, 0, 1'b1, frz);
      step(1'b0, 0, 1'b0, frz);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_level", level, 0);
      check("rst_target", target, 0);
      check("rst_strobe", level_strobe, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_decay[9];
      bit prev_fb;
      bit fb;
      int mic;
      model_reset();
      vecs[0] = '{2048, 3000, 2100, 2500, 7};
      vecs[1] = '{4095, 0, 0, 0, 15};
      vecs[2] = '{1000, 1000, 1000, 1000, 0};
      vecs[3] = '{2047, 2047, 2047, 2047, 0};
      vecs[4] = '{2176, 2175, 2048, 0, 1};
      vecs[5] = '{3967, 2048, 2048, 2048, 14};
      exp_decay = '{9, 9, 8, 7, 6, 5, 4, 3, 3};

      repeat (2) @(posedge clk);
      #1;
      check("por_level", level, 0);
      check("por_target", target, 0);
      check("por_strobe", level_strobe, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-window discards the partial window.
      send_window(4095, 4095, 4095, 4095, 1'b0);
      frame(1'b0);
      check("pre_rst_level", level, 15);
      step(1'b1, 4095, 1'b0, 1'b0);
      step(1'b1, 4095, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 2048, 1'b0, 1'b0);
      step(1'b1, 2048, 1'b0, 1'b0);
      check("partial_discard", target, 0);
      step(1'b1, 2048, 1'b0, 1'b0);
      step(1'b1, 2048, 1'b0, 1'b0);
      check("post_rst_target", target, 0);

      foreach (vecs[i]) begin
         exp_q.push_back(4'(vecs[i].exp_target));
         send_window(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, 1'b0);
         check("tbl_target", target, int'(exp_q.pop_front()));
      end

      // Attack to 9, then hold two frames and decay one step per frame to 3.
      send_window(3200, 2048, 2048, 2048, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      check("atk_level", level, 9);
      check("atk_strobe", level_strobe, 1);
      step(1'b0, 0, 1'b0, 1'b0);
      check("atk_strobe_off", level_strobe, 0);
      send_window(2432, 2048, 2048, 2048, 1'b0);
      foreach (exp_decay[k]) begin
         frame(1'b0);
         check("decay_level", level, exp_decay[k]);
      end

      // Freeze: window still completes, level and strobe held.
      send_window(3584, 2048, 2048, 2048, 1'b1);
      check("frz_target", target, 12);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 0, 1'b1, 1'b1);
         check("frz_level", level, 3);
         check("frz_strobe", level_strobe, 0);
         step(1'b0, 0, 1'b0, 1'b1);
      end
      step(1'b0, 0, 1'b0, 1'b0);
      frame(1'b0);
      check("unfrz_level", level, 12);

      // Window completion colliding with frame_begin uses the old target.
      do_reset();
      send_window(2304, 2048, 2048, 2048, 1'b0);
      step(1'b1, 2048, 1'b0, 1'b0);
      step(1'b1, 2048, 1'b0, 1'b0);
      step(1'b1, 2048, 1'b0, 1'b0);
      step(1'b1, 4095, 1'b1, 1'b0);
      check("coll_level", level, 2);
      check("coll_target", target, 15);
      step(1'b0, 0, 1'b0, 1'b0);
      frame(1'b0);
      check("coll_next_level", level, 15);

      // Re-attack while decaying restarts the hold.
      send_window(2432, 2048, 2048, 2048, 1'b0);
      repeat (11) frame(1'b0);
      check("redecay_level", level, 6);
      send_window(3328, 2048, 2048, 2048, 1'b0);
      frame(1'b0);
      check("reatk_level", level, 10);
      send_window(2048, 2048, 2048, 2048, 1'b0);
      frame(1'b0);
      check("reatk_hold1", level, 10);
      frame(1'b0);
      check("reatk_hold2", level, 10);
      frame(1'b0);
      check("reatk_decay", level, 9);

      // Random traffic, frames never on adjacent cycles.
      prev_fb = 1'b0;
      for (int n = 0; n < 800; n++) begin
         fb  = !prev_fb && ($urandom_range(0, 3) == 0);
         mic = ($urandom_range(0, 3) == 0) ? 2048 : int'($urandom_range(0, 4095));
         step(1'($urandom_range(0, 1)), mic, fb, ($urandom_range(0, 7) == 0));
         prev_fb = fb;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
